// File: rtl/matrix_bank_reader.sv
// Row-major sweep reader over NUMREADS parallel banks, with a 2-entry skid FIFO
// on the output that throttles issue so read data always has a slot.
//  state | meaning
//  IDLE  | waiting for a valid start
//  ISSUE | issuing reads, one coordinate per rden
//  DRAIN | all reads issued, emptying the FIFO until out_last pops
module matrix_bank_reader #(
    parameter int DW       = 16,
    parameter int ROWWIDTH = 4,
    parameter int COLWIDTH = 4,
    parameter int NUMREADS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  int            row_first,
    input  int            row_last,
    input  logic          abort,
    output logic          rden        [0:NUMREADS-1],
    output int            row_rd_addr [0:NUMREADS-1],
    output int            col_rd_addr [0:NUMREADS-1],
    input  logic [DW-1:0] rd_data     [0:NUMREADS-1],
    output logic [DW-1:0] out_data    [0:NUMREADS-1],
    output int            out_row,
    output int            out_col,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state;
    int            last_row;
    int            iss_row;
    int            iss_col;
    int            prev_row;
    int            prev_col;
    logic          inflight;
    logic [1:0]    occ;
    logic          head;
    logic [DW-1:0] fifo_data [0:1][0:NUMREADS-1];
    int            fifo_row  [0:1];
    int            fifo_col  [0:1];

    logic       issue;
    logic       pop;
    logic       push;
    logic       wr_slot;
    logic       range_ok;
    logic       final_coord;
    logic [2:0] pending;

    assign busy      = (state != IDLE);
    assign out_valid = (occ != 2'd0);
    assign out_row   = fifo_row[head];
    assign out_col   = fifo_col[head];
    assign out_last  = out_valid && (fifo_row[head] == last_row) && (fifo_col[head] == COLWIDTH - 1);

    always_comb begin
        pop         = out_valid && out_ready;
        pending     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        issue       = (state == ISSUE) && !abort && (pending < 3'd2);
        push        = inflight && !abort;
        // with two entries held a push always coincides with a pop, so the freed head slot is reused
        wr_slot     = head ^ occ[0];
        final_coord = (iss_row == last_row) && (iss_col == COLWIDTH - 1);
        range_ok    = (row_first >= 0) && (row_first <= row_last) && (row_last < ROWWIDTH);
    end

    always_comb begin
        for (int l = 0; l < NUMREADS; l++) begin
            rden[l]        = issue;
            row_rd_addr[l] = issue ? iss_row : prev_row;
            col_rd_addr[l] = issue ? iss_col : prev_col;
            out_data[l]    = fifo_data[head][l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_row <= 0;
            iss_row  <= 0;
            iss_col  <= 0;
            prev_row <= 0;
            prev_col <= 0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                fifo_row[s] <= 0;
                fifo_col[s] <= 0;
                for (int l = 0; l < NUMREADS; l++) fifo_data[s][l] <= '0;
            end
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            state    <= ISSUE;
                            last_row <= row_last;
                            iss_row  <= row_first;
                            iss_col  <= 0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (abort)                     state <= IDLE;
                    else if (issue && final_coord) state <= DRAIN;
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                prev_row <= iss_row;
                prev_col <= iss_col;
                if (iss_col == COLWIDTH - 1) begin
                    iss_col <= 0;
                    iss_row <= iss_row + 1;
                end else begin
                    iss_col <= iss_col + 1;
                end
            end

            inflight <= issue;

            if (abort && busy) begin
                occ <= 2'd0;
            end else begin
                if (push) begin
                    // prev_row/prev_col still hold the coordinate issued last cycle
                    fifo_row[wr_slot] <= prev_row;
                    fifo_col[wr_slot] <= prev_col;
                    for (int l = 0; l < NUMREADS; l++) fifo_data[wr_slot][l] <= rd_data[l];
                end
                if (pop) head <= ~head;
                occ <= occ + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule
